// File: rtl/looper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : looper_pkg
//  Purpose  : Shared types and defaults for the multi-track audio looper.
//             State encoding, key decode and default geometry live here.
//  Config   : LOOPER_OVERDUB_EN (consumed by looper_ctrl)
//  Revision : 1.0  initial release
// ============================================================================
package looper_pkg;

    localparam int C_NUM_TRACKS_DEF = 4;
    localparam int C_ADDR_W_DEF     = 20;

    // Controller state, exported unchanged on o_state
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RECORD  = 3'd2,
        ST_LOOP    = 3'd3,
        ST_OVERDUB = 3'd4
    } state_e;

    // The single key acted on in a cycle after priority resolution
    typedef enum logic [2:0] {
        KEY_NONE = 3'd0,
        KEY_REC  = 3'd1,
        KEY_PLAY = 3'd2,
        KEY_CLR  = 3'd3,
        KEY_SEL  = 3'd4
    } key_e;

    // Simultaneous presses: rec beats play beats clr beats sel
    function automatic key_e key_decode(input logic rec, input logic play,
                                        input logic clr, input logic sel);
        key_e k;
        if (rec)       k = KEY_REC;
        else if (play) k = KEY_PLAY;
        else if (clr)  k = KEY_CLR;
        else if (sel)  k = KEY_SEL;
        else           k = KEY_NONE;
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/looper_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : looper_addr_gen
//  Purpose  : Frame offset counter with loop-length wrap, and the registered
//             SRAM address {track, offset} (track selects the region base).
//  Config   : none
//  Revision : 1.0  initial release
// ============================================================================
module looper_addr_gen #(
    parameter int ADDR_W = 20,
    parameter int TRK_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [TRK_W-1:0]        i_track,    // track that owns the next frame
    input  logic                    i_clr,      // force offset to 0 (wins over i_inc)
    input  logic                    i_inc,      // advance one frame
    input  logic                    i_wrap_en,  // wrap at i_len-1 (playback)
    input  logic [ADDR_W-TRK_W-1:0] i_len,      // 0 means the full region
    output logic [ADDR_W-TRK_W-1:0] o_offset,
    output logic [ADDR_W-1:0]       o_addr
);

    localparam int LW = ADDR_W - TRK_W;

    logic [LW-1:0]     offset_q, offset_d;
    logic [LW-1:0]     w_last;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next offset; a full-region length is stored as 0 so len-1 is all ones
    always_comb begin
        w_last   = i_len - LW'(1);
        offset_d = offset_q;
        if (i_inc) begin
            if (i_wrap_en && (offset_q == w_last)) offset_d = '0;
            else                                   offset_d = offset_q + LW'(1);
        end
        if (i_clr) offset_d = '0;
        addr_d = {i_track, offset_d};
    end

    // Offset and address registers; address tracks the updated offset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            offset_q <= '0;
            addr_q   <= '0;
        end else begin
            offset_q <= offset_d;
            addr_q   <= addr_d;
        end
    end

    assign o_offset = offset_q;
    assign o_addr   = addr_q;

endmodule
`default_nettype wire

// File: rtl/looper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : looper_ctrl
//  Purpose  : Multi-track looper controller: key-driven FSM, per-track loop
//             lengths and valid mask, SRAM address / enable generation.
//  Config   : LOOPER_OVERDUB_EN - when defined, rec in LOOP enters OVERDUB.
//  Note     : o_len is ADDR_W-TRK_W bits wide, so a loop filling its whole
//             region reads as 0 there (o_valid tells it apart from empty).
//  Revision : 1.0  initial release
// ============================================================================
module looper_ctrl import looper_pkg::*; #(
    parameter  int NUM_TRACKS = C_NUM_TRACKS_DEF,
    parameter  int ADDR_W     = C_ADDR_W_DEF,
    localparam int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_init_done,
    input  logic                    i_sample_tick,
    input  logic                    i_key_rec,
    input  logic                    i_key_play,
    input  logic                    i_key_sel,
    input  logic                    i_key_clr,
    output logic [2:0]              o_state,
    output logic [TRK_W-1:0]        o_track,
    output logic [ADDR_W-1:0]       o_addr,
    output logic                    o_rec_en,
    output logic                    o_play_en,
    output logic [NUM_TRACKS-1:0]   o_valid,
    output logic [ADDR_W-TRK_W-1:0] o_len
);

    localparam int LW = ADDR_W - TRK_W;

    state_e                state_q, state_d;
    logic [TRK_W-1:0]      track_q, track_d;
    logic [NUM_TRACKS-1:0] valid_q, valid_d;
    logic [LW-1:0]         len_q [NUM_TRACKS];
    logic [LW-1:0]         len_d [NUM_TRACKS];
    logic                  rec_en_q, rec_en_d;
    logic                  play_en_q, play_en_d;

    key_e                  w_key;
    logic [LW-1:0]         w_offset;
    logic                  w_off_clr;
    logic                  w_off_inc;
    logic                  w_wrap_en;
    logic                  w_rec_nonempty;

    assign w_key = key_decode(i_key_rec, i_key_play, i_key_clr, i_key_sel);

    // FSM next state, track/valid/length updates and offset commands
    always_comb begin
        state_d   = state_q;
        track_d   = track_q;
        valid_d   = valid_q;
        len_d     = len_q;
        w_off_clr = 1'b0;
        w_off_inc = 1'b0;
        w_wrap_en = 1'b0;
        // the tick of this cycle counts before a rec key closes the take
        w_rec_nonempty = i_sample_tick || (w_offset != '0);

        case (state_q)
            ST_INIT: begin
                if (i_init_done) state_d = ST_IDLE;
            end

            ST_IDLE: begin
                w_off_clr = 1'b1;
                case (w_key)
                    KEY_REC:  state_d = ST_RECORD;
                    KEY_PLAY: if (valid_q[track_q]) state_d = ST_LOOP;
                    KEY_CLR:  valid_d[track_q] = 1'b0;
                    KEY_SEL:  track_d = (track_q == TRK_W'(NUM_TRACKS - 1)) ?
                                        '0 : track_q + TRK_W'(1);
                    default:  ;
                endcase
            end

            ST_RECORD: begin
                w_off_inc = i_sample_tick;
                if (i_sample_tick && (w_offset == '1)) begin
                    // region full: the length wraps to 0, meaning full region
                    len_d[track_q]   = '0;
                    valid_d[track_q] = 1'b1;
                    state_d          = ST_LOOP;
                    w_off_clr        = 1'b1;
                end else if (w_key == KEY_REC) begin
                    w_off_clr = 1'b1;
                    if (w_rec_nonempty) begin
                        len_d[track_q]   = w_offset + LW'(i_sample_tick);
                        valid_d[track_q] = 1'b1;
                        state_d          = ST_LOOP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LOOP: begin
                w_off_inc = i_sample_tick;
                w_wrap_en = 1'b1;
                if (w_key == KEY_REC) begin
`ifdef LOOPER_OVERDUB_EN
                    state_d = ST_OVERDUB;
`else
                    state_d = ST_LOOP;
`endif
                end else if (w_key == KEY_PLAY) begin
                    state_d   = ST_IDLE;
                    w_off_clr = 1'b1;
                end
            end

`ifdef LOOPER_OVERDUB_EN
            ST_OVERDUB: begin
                w_off_inc = i_sample_tick;
                w_wrap_en = 1'b1;
                if (w_key == KEY_REC) begin
                    state_d = ST_LOOP;
                end else if (w_key == KEY_PLAY) begin
                    state_d   = ST_IDLE;
                    w_off_clr = 1'b1;
                end
            end
`endif

            default: state_d = ST_INIT;
        endcase

        rec_en_d  = (state_d == ST_RECORD) || (state_d == ST_OVERDUB);
        play_en_d = (state_d == ST_LOOP)   || (state_d == ST_OVERDUB);
    end

    // State, mask, length and enable registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_INIT;
            track_q   <= '0;
            valid_q   <= '0;
            len_q     <= '{default: '0};
            rec_en_q  <= 1'b0;
            play_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            track_q   <= track_d;
            valid_q   <= valid_d;
            len_q     <= len_d;
            rec_en_q  <= rec_en_d;
            play_en_q <= play_en_d;
        end
    end

    looper_addr_gen #(
        .ADDR_W (ADDR_W),
        .TRK_W  (TRK_W)
    ) u_addr_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_track   (track_d),
        .i_clr     (w_off_clr),
        .i_inc     (w_off_inc),
        .i_wrap_en (w_wrap_en),
        .i_len     (len_q[track_q]),
        .o_offset  (w_offset),
        .o_addr    (o_addr)
    );

    assign o_state   = state_q;
    assign o_track   = track_q;
    assign o_rec_en  = rec_en_q;
    assign o_play_en = play_en_q;
    assign o_valid   = valid_q;
    assign o_len     = len_q[track_q];

endmodule
`default_nettype wire

// File: tb/tb_looper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_looper_ctrl
//  Purpose  : Self-checking bench for looper_ctrl (NUM_TRACKS=4, ADDR_W=6):
//             directed scenarios plus randomized keys/ticks against a
//             frame-level behavioural model.
//  Config   : LOOPER_OVERDUB_EN selects the overdub expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_looper_ctrl;
    import looper_pkg::*;

    localparam int NT  = 4;
    localparam int AW  = 6;
    localparam int TW  = 2;
    localparam int LW  = AW - TW;
    localparam int RSZ = 1 << LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done = 1'b0;
    logic          tick = 1'b0;
    logic          k_rec = 1'b0, k_play = 1'b0, k_sel = 1'b0, k_clr = 1'b0;
    logic [2:0]    o_state;
    logic [TW-1:0] o_track;
    logic [AW-1:0] o_addr;
    logic          o_rec_en, o_play_en;
    logic [NT-1:0] o_valid;
    logic [LW-1:0] o_len;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    looper_ctrl #(.NUM_TRACKS(NT), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
        .i_sample_tick(tick), .i_key_rec(k_rec), .i_key_play(k_play),
        .i_key_sel(k_sel), .i_key_clr(k_clr),
        .o_state(o_state), .o_track(o_track), .o_addr(o_addr),
        .o_rec_en(o_rec_en), .o_play_en(o_play_en),
        .o_valid(o_valid), .o_len(o_len)
    );

    // ---------------- behavioural model (frame level) ----------------
    typedef enum int {M_INIT, M_IDLE, M_REC, M_LOOP, M_OD} mstate_e;
    mstate_e ms = M_INIT;
    int      mtrack = 0, moff = 0, mrec = 0;
    int      mlen [NT];
    bit      mvalid [NT];

    task automatic model_step(input bit r, input bit id, input bit t,
                              input bit kr, input bit kp, input bit ks, input bit kc);
        if (r) begin
            ms = M_INIT; mtrack = 0; moff = 0; mrec = 0;
            for (int i = 0; i < NT; i++) begin mlen[i] = 0; mvalid[i] = 0; end
            return;
        end
        case (ms)
            M_INIT: if (id) ms = M_IDLE;
            M_IDLE: begin
                if (kr) begin ms = M_REC; moff = 0; mrec = 0; end
                else if (kp) begin if (mvalid[mtrack]) begin ms = M_LOOP; moff = 0; end end
                else if (kc) mvalid[mtrack] = 0;
                else if (ks) mtrack = (mtrack + 1) % NT;
            end
            M_REC: begin
                if (t) begin moff++; mrec++; end
                if (mrec == RSZ) begin
                    mlen[mtrack] = RSZ; mvalid[mtrack] = 1; ms = M_LOOP; moff = 0;
                end else if (kr) begin
                    if (mrec > 0) begin
                        mlen[mtrack] = mrec; mvalid[mtrack] = 1; ms = M_LOOP;
                    end else begin
                        ms = M_IDLE;
                    end
                    moff = 0;
                end
            end
            default: begin // M_LOOP, M_OD
                if (t) moff = (moff + 1) % mlen[mtrack];
                if (kr) begin
`ifdef LOOPER_OVERDUB_EN
                    ms = (ms == M_LOOP) ? M_OD : M_LOOP;
`endif
                end else if (kp) begin
                    ms = M_IDLE; moff = 0;
                end
            end
        endcase
    endtask

    function automatic logic [2:0] exp_state();
        case (ms)
            M_INIT:  return ST_INIT;
            M_IDLE:  return ST_IDLE;
            M_REC:   return ST_RECORD;
            M_LOOP:  return ST_LOOP;
            default: return ST_OVERDUB;
        endcase
    endfunction

    function automatic logic [NT-1:0] exp_valid();
        logic [NT-1:0] v;
        for (int i = 0; i < NT; i++) v[i] = mvalid[i];
        return v;
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        a = AW'(mtrack * RSZ + moff);
        l = LW'(mlen[mtrack] % RSZ);
        return {exp_state(), TW'(mtrack), a,
                (ms == M_REC) || (ms == M_OD), (ms == M_LOOP) || (ms == M_OD),
                exp_valid(), l};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {o_state, o_track, o_addr, o_rec_en, o_play_en, o_valid, o_len};
    endfunction

    // One clock: drive inputs, advance model at the edge, settle outputs
    task automatic step(input bit r, input bit id, input bit t,
                        input bit kr, input bit kp, input bit ks, input bit kc);
        rst = r; init_done = id; tick = t;
        k_rec = kr; k_play = kp; k_sel = ks; k_clr = kc;
        @(posedge clk);
        model_step(r, id, t, kr, kp, ks, kc);
        #1;
        rst = 1'b0; tick = 1'b0;
        k_rec = 1'b0; k_play = 1'b0; k_sel = 1'b0; k_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1, 1);
        vectors++;
        if (o_state !== ST_INIT) begin miscompares++;
            $display("FAIL reset_state got %0d want %0d", o_state, ST_INIT); end
        vectors++;
        if (o_addr !== '0 || o_track !== '0) begin miscompares++;
            $display("FAIL reset_addr_track got %0d/%0d want 0/0", o_addr, o_track); end
        vectors++;
        if (o_rec_en !== 1'b0 || o_play_en !== 1'b0) begin miscompares++;
            $display("FAIL reset_enables got %b%b want 00", o_rec_en, o_play_en); end
        vectors++;
        if (o_valid !== '0 || o_len !== '0) begin miscompares++;
            $display("FAIL reset_valid_len got %b/%0d want 0000/0", o_valid, o_len); end
    endtask

    task automatic test_init();
        bit kr, kp, ks, kc, t;
        for (int i = 0; i < 100; i++) begin
            kr = ($urandom_range(0, 3) == 0); kp = ($urandom_range(0, 3) == 0);
            ks = ($urandom_range(0, 3) == 0); kc = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 1) == 0);
            step(0, 0, t, kr, kp, ks, kc);
            vectors++;
            if (o_state !== ST_INIT || o_track !== '0 || o_valid !== '0 ||
                o_addr !== '0 || o_rec_en !== 1'b0 || o_play_en !== 1'b0) begin
                miscompares++;
                $display("FAIL init_hold cyc %0d got state %0d trk %0d addr %0d want INIT/0/0",
                         i, o_state, o_track, o_addr);
            end
        end
        step(0, 1, 0, 0, 0, 0, 0);
        vectors++;
        if (o_state !== ST_IDLE) begin miscompares++;
            $display("FAIL init_to_idle got %0d want %0d", o_state, ST_IDLE); end
    endtask

    task automatic test_record_basic();
        int seq [6] = '{1, 2, 3, 4, 0, 1};
        step(0, 1, 0, 1, 0, 0, 0);
        vectors++;
        if (o_state !== ST_RECORD || o_rec_en !== 1'b1 || o_play_en !== 1'b0 || o_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL rec_enter got st %0d rec %b play %b addr %0d want 2/1/0/0",
                     o_state, o_rec_en, o_play_en, o_addr);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0, 0);
            vectors++;
            if (o_addr !== AW'(i + 1)) begin miscompares++;
                $display("FAIL rec_addr tick %0d got %0d want %0d", i, o_addr, i + 1); end
        end
        step(0, 1, 0, 1, 0, 0, 0);
        vectors++;
        if (o_state !== ST_LOOP || o_len !== 4'd5 || o_valid !== 4'b0001 ||
            o_addr !== 6'd0 || o_play_en !== 1'b1 || o_rec_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rec_stop got st %0d len %0d valid %b addr %0d want 3/5/0001/0",
                     o_state, o_len, o_valid, o_addr);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            vectors++;
            if (o_addr !== AW'(seq[i])) begin miscompares++;
                $display("FAIL loop_addr tick %0d got %0d want %0d", i, o_addr, seq[i]); end
        end
    endtask

    task automatic test_auto_complete();
        step(0, 1, 0, 0, 1, 0, 0);            // leave LOOP
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        vectors++;
        if (o_state !== ST_IDLE || o_track !== 2'd2) begin miscompares++;
            $display("FAIL sel_twice got st %0d trk %0d want 1/2", o_state, o_track); end
        step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (o_state !== ST_RECORD || o_addr !== 6'd47) begin miscompares++;
            $display("FAIL full_pre got st %0d addr %0d want 2/47", o_state, o_addr); end
        step(0, 1, 1, 0, 0, 0, 0);
        // 16-frame length reads as 0 in the 4-bit o_len port
        vectors++;
        if (o_state !== ST_LOOP || o_addr !== 6'd32 || o_len !== 4'd0 || o_valid !== 4'b0101) begin
            miscompares++;
            $display("FAIL full_auto got st %0d addr %0d len %0d valid %b want 3/32/0/0101",
                     o_state, o_addr, o_len, o_valid);
        end
        for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (o_addr !== 6'd47) begin miscompares++;
            $display("FAIL full_top got %0d want 47", o_addr); end
        step(0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (o_addr !== 6'd32) begin miscompares++;
            $display("FAIL full_wrap got %0d want 32", o_addr); end
    endtask

    task automatic test_empty();
        step(0, 1, 0, 0, 1, 0, 0);            // to IDLE
        step(0, 1, 0, 0, 0, 1, 0);            // track 3
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        vectors++;
        if (o_state !== ST_IDLE || o_valid !== 4'b0101 || o_rec_en !== 1'b0) begin miscompares++;
            $display("FAIL empty_take got st %0d valid %b want 1/0101", o_state, o_valid); end
        step(0, 1, 0, 0, 1, 0, 0);
        vectors++;
        if (o_state !== ST_IDLE || o_play_en !== 1'b0) begin miscompares++;
            $display("FAIL play_empty got st %0d play %b want 1/0", o_state, o_play_en); end
    endtask

    task automatic test_overdub();
        step(0, 1, 0, 0, 0, 1, 0);            // track 0, 5-frame loop
        step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0);            // tick + rec + play
        vectors++;
`ifdef LOOPER_OVERDUB_EN
        if (o_state !== ST_OVERDUB || o_rec_en !== 1'b1 || o_play_en !== 1'b1 || o_addr !== 6'd2) begin
            miscompares++;
            $display("FAIL overdub_enter got st %0d rec %b play %b addr %0d want 4/1/1/2",
                     o_state, o_rec_en, o_play_en, o_addr);
        end
`else
        if (o_state !== ST_LOOP || o_rec_en !== 1'b0 || o_play_en !== 1'b1 || o_addr !== 6'd2) begin
            miscompares++;
            $display("FAIL overdub_off got st %0d rec %b play %b addr %0d want 3/0/1/2",
                     o_state, o_rec_en, o_play_en, o_addr);
        end
`endif
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (o_addr !== 6'd0 || o_play_en !== 1'b1) begin miscompares++;
            $display("FAIL overdub_wrap got addr %0d want 0", o_addr); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (o_state !== ST_INIT || o_valid !== '0 || o_addr !== '0 ||
            o_rec_en !== 1'b0 || o_play_en !== 1'b0 || o_len !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got st %0d valid %b addr %0d en %b%b len %0d want 0/0/0/00/0",
                     o_state, o_valid, o_addr, o_rec_en, o_play_en, o_len);
        end
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit r, t, kr, kp, ks, kc;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 599) == 0);
            t  = ($urandom_range(0, 1) == 0);
            kr = ($urandom_range(0, 13) == 0);
            kp = ($urandom_range(0, 9) == 0);
            ks = ($urandom_range(0, 7) == 0);
            kc = ($urandom_range(0, 15) == 0);
            step(r, 1, t, kr, kp, ks, kc);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got %h want %h (state,trk,addr,rec,play,valid,len)",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_record_basic();
        test_auto_complete();
        test_empty();
        test_overdub();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/looper_ctrl.md
LOOPER_CTRL -- requirements
Module: looper_ctrl

Interface
REQ-001 SHALL have parameter NUM_TRACKS, default 4, meaning the number of independent loop tracks (power of two, 1..8).
REQ-002 SHALL have parameter ADDR_W, default 20, meaning the SRAM word-address width.
REQ-003 SHALL have parameter TRK_W = $clog2(NUM_TRACKS) (min 1), meaning the track-index width (derived, not overridable).
REQ-004 i_clk  in  1  single clock for all logic.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_init_done  in  1  codec I2C initialisation complete (level).
REQ-007 i_sample_tick  in  1  one-cycle pulse per audio frame.
REQ-008 i_key_rec / i_key_play / i_key_sel / i_key_clr  in  1 each  debounced one-cycle key pulses.
REQ-009 o_state  out  3  current state encoding from looper_pkg.
REQ-010 o_track  out  TRK_W  selected track.
REQ-011 o_addr  out  ADDR_W  SRAM word address for the current frame.
REQ-012 o_rec_en / o_play_en  out  1 each  write / read-out enable for the current frame.
REQ-013 o_valid  out  NUM_TRACKS  per-track "holds a recorded loop" mask.
REQ-014 o_len  out  ADDR_W-TRK_W  loop length of the selected track, in frames.

Function
REQ-015 SHALL partition SRAM into NUM_TRACKS equal regions; base = track << (ADDR_W-TRK_W); region size RSZ = 2^(ADDR_W-TRK_W).
REQ-016 SHALL implement states INIT, IDLE, RECORD, LOOP, OVERDUB.
REQ-017 INIT->IDLE on the first cycle i_init_done=1; all keys ignored in INIT.
REQ-018 IDLE: i_key_sel increments o_track modulo NUM_TRACKS; i_key_clr clears o_valid[o_track]; i_key_rec -> RECORD with offset 0, length 0; i_key_play -> LOOP with offset 0 only if o_valid[o_track], else ignored.
REQ-019 RECORD: o_rec_en=1; each i_sample_tick increments offset and length by 1.
REQ-020 RECORD: i_key_rec with length>0 -> LOOP, stores length, sets o_valid[o_track], offset reset to 0; with length=0 -> IDLE, o_valid unchanged.
REQ-021 RECORD: tick when offset=RSZ-1 completes the recording (length=RSZ) and transitions to LOOP on that cycle without a key.
REQ-022 LOOP: o_play_en=1; each tick increments offset; offset=len-1 wraps to 0.
REQ-023 LOOP: i_key_rec -> OVERDUB; i_key_play -> IDLE.
REQ-024 OVERDUB: o_play_en=1 and o_rec_en=1 on the same address; wrap identical to LOOP; i_key_rec -> LOOP; i_key_play -> IDLE.
REQ-025 i_key_sel and i_key_clr SHALL be ignored outside IDLE.
REQ-026 Simultaneous key pulses: priority rec > play > clr > sel; only the highest is acted on.
REQ-027 Key pulse and tick in same cycle: the tick is applied first at the current state, then the transition (offset of the new state is set per the transition rule).
REQ-028 o_addr = base | offset, registered; o_addr, o_rec_en, o_play_en update one cycle after the tick or transition.
REQ-029 o_rec_en/o_play_en SHALL be 0 in INIT and IDLE.

Reset
REQ-030 i_rst SHALL force state INIT, o_track 0, o_addr 0, o_rec_en 0, o_play_en 0, o_valid 0, all stored lengths 0, at any point including mid-RECORD or mid-OVERDUB.

Configuration
REQ-031 Macro LOOPER_OVERDUB_EN defined: OVERDUB state and REQ-023 rec transition present.
REQ-032 Macro LOOPER_OVERDUB_EN undefined: OVERDUB not implemented; i_key_rec in LOOP is ignored; all else unchanged.

Structure
REQ-033 looper_pkg SHALL hold the state enum (3-bit) and the default NUM_TRACKS/ADDR_W constants.
REQ-034 Sub-module looper_addr_gen SHALL hold the offset counter, wrap compare and base concatenation; looper_ctrl holds the FSM, length registers and valid mask.

Verification
REQ-035 i_init_done low 100 cycles then high -> INIT held, then IDLE one cycle later; keys during INIT have no effect.
REQ-036 Track 0 rec, 5 ticks, rec -> LOOP, o_len=5, o_valid=0001, o_addr sequence 0,1,2,3,4,0,1.
REQ-037 sel twice, rec with ADDR_W=6, NUM_TRACKS=4, 16 ticks -> auto LOOP, o_len=16, o_addr wraps 47->32.
REQ-038 rec then rec with no tick -> IDLE, o_valid unchanged; play on empty track -> stays IDLE.
REQ-039 In LOOP, rec+play same cycle -> OVERDUB (macro on) / stays LOOP (macro off); o_rec_en and o_play_en both 1 in OVERDUB.
REQ-040 i_rst asserted mid-OVERDUB -> next cycle INIT, o_valid=0, o_addr=0, enables 0.
